lsu_bus_ctrl: RTL and testbench

//  Data-memory bus controller directly downstream of the memory stage.

---
 rtl/lsu_bus_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: data-memory bus controller behind the memory stage.
// Runs one req/gnt/rvalid transaction per access and holds the pipeline
// stalled until that transaction retires. Transactions are aborted after
// TIMEOUT_CYC cycles spent waiting on the bus.
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        we_re,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  mask,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_mask_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Last waiting cycle index; the counter equals the number of REQ+RESP
    // cycles already spent, so hitting this value means the budget is used up.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 32'd1);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [15:0] cnt_r;

    // The bus output registers double as the latched request: they are
    // loaded when the access is accepted and cleared when REQ is left.
    logic        bus_req_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r;
    logic [31:0] bus_wdata_r;
    logic [3:0]  bus_mask_r;

    logic [31:0] load_data_r;
    logic        load_valid_r;
    logic        err_r;

    logic        store_done_s;
    logic        load_done_s;
    logic        timeout_s;
    logic        resp_wait_s;
    logic        stall_s;

    // Byte offset is carried entirely by the lane mask.
    logic        addr_lo_unused_s;
    assign addr_lo_unused_s = ^addr[1:0];

    // Decode what the bus did this cycle; completion has priority over abort
    always_comb begin
        store_done_s = 1'b0;
        load_done_s  = 1'b0;
        timeout_s    = 1'b0;
        resp_wait_s  = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (bus_gnt_i && bus_we_r) begin
                    store_done_s = 1'b1;
                end else if (bus_gnt_i && bus_rvalid_i) begin
                    load_done_s = 1'b1;
                end else if (cnt_r >= CNT_LAST) begin
                    timeout_s = 1'b1;
                end else if (bus_gnt_i) begin
                    resp_wait_s = 1'b1;
                end else begin
                    resp_wait_s = 1'b0;
                end
            end
            ST_RESP: begin
                if (bus_rvalid_i) begin
                    load_done_s = 1'b1;
                end else if (cnt_r >= CNT_LAST) begin
                    timeout_s = 1'b1;
                end else begin
                    timeout_s = 1'b0;
                end
            end
            default: begin
                timeout_s = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_req) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (store_done_s || load_done_s || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else if (resp_wait_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (load_done_s || timeout_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_DONE: begin
                // A request seen here still belongs to the retiring access.
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: freeze the pipeline until the access retires
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: stall_s = mem_req;
            ST_REQ:  stall_s = 1'b1;
            ST_RESP: stall_s = 1'b1;
            ST_DONE: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Wait-cycle counter; saturates so it can never wrap back below the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else if ((state_r == ST_IDLE) && mem_req) begin
            cnt_r <= 16'd0;
        end else if (((state_r == ST_REQ) || (state_r == ST_RESP)) && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Latch the accepted request into the bus registers; drop them once granted or aborted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_wdata_r <= 32'd0;
            bus_mask_r  <= 4'd0;
        end else if ((state_r == ST_IDLE) && mem_req) begin
            bus_req_r   <= 1'b1;
            bus_we_r    <= we_re;
            bus_addr_r  <= {addr[31:2], 2'b00};
            bus_wdata_r <= wdata;
            bus_mask_r  <= mask;
        end else if ((state_r == ST_REQ) && (state_nxt_s != ST_REQ)) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_wdata_r <= 32'd0;
            bus_mask_r  <= 4'd0;
        end else begin
            bus_req_r   <= bus_req_r;
            bus_we_r    <= bus_we_r;
            bus_addr_r  <= bus_addr_r;
            bus_wdata_r <= bus_wdata_r;
            bus_mask_r  <= bus_mask_r;
        end
    end

    // Retirement pulses and load data capture, visible during DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_valid_r <= 1'b0;
            err_r        <= 1'b0;
            load_data_r  <= 32'd0;
        end else begin
            load_valid_r <= load_done_s;
            err_r        <= timeout_s;
            if (load_done_s) begin
                load_data_r <= bus_rdata_i;
            end else if (timeout_s && !bus_we_r) begin
                load_data_r <= 32'd0;
            end else begin
                load_data_r <= load_data_r;
            end
        end
    end

    assign stall_o      = stall_s;
    assign load_data_o  = load_data_r;
    assign load_valid_o = load_valid_r;
    assign err_o        = err_r;
    assign bus_req_o    = bus_req_r;
    assign bus_we_o     = bus_we_r;
    assign bus_addr_o   = bus_addr_r;
    assign bus_wdata_o  = bus_wdata_r;
    assign bus_mask_o   = bus_mask_r;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl. The reference model works per access:
// from the grant delay g and rvalid delay r it computes how many bus-wait
// cycles the access takes, whether it aborts, and what the outputs must be.
module tb_lsu_bus_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req = 1'b0;
    logic        we_re = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  mask = 4'd0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;

    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_mask_o;

    int          total = 0;
    int          bad = 0;
    logic [31:0] ld_model = 32'd0;
    int          req_starts = 0;
    logic        req_prev = 1'b0;

    always #5 clk = ~clk;

    lsu_bus_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_req      (mem_req),
        .we_re        (we_re),
        .addr         (addr),
        .wdata        (wdata),
        .mask         (mask),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .err_o        (err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_mask_o   (bus_mask_o),
        .bus_gnt_i    (gnt),
        .bus_rvalid_i (rvalid),
        .bus_rdata_i  (rdata)
    );

    // Count bus request starts, sampled away from the active edge
    always @(negedge clk) begin
        if (bus_req_o && !req_prev) req_starts <= req_starts + 1;
        req_prev <= bus_req_o;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles: no request, random bus noise must be ignored
    task automatic idle_cycles(input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) begin
            next_cycle();
            mem_req = 1'b0; we_re = 1'($urandom); addr = $urandom; wdata = $urandom;
            mask = 4'($urandom); gnt = 1'($urandom); rvalid = 1'($urandom); rdata = $urandom;
            #1;
            total++;
            if ({stall_o, load_valid_o, err_o, bus_req_o} !== 4'b0000) begin
                bad++;
                $display("FAIL %s idle ctl got=%b exp=0000", tag,
                         {stall_o, load_valid_o, err_o, bus_req_o});
            end
            total++;
            if (load_data_o !== ld_model) begin
                bad++;
                $display("FAIL %s idle load_data got=%h exp=%h", tag, load_data_o, ld_model);
            end
        end
    endtask

    // One complete access, checked every cycle against the per-access model
    task automatic run_access(input logic a_we, input logic [31:0] a_addr,
                              input logic [31:0] a_wdata, input logic [3:0] a_mask,
                              input int g, input int r, input logic [31:0] a_rdata,
                              input logic hold, input string tag);
        int         comp;
        int         n;
        logic       abort;
        logic       in_req;
        logic [2:0] ctl_exp;
        logic [69:0] bus_exp;
        comp  = a_we ? g : g + r;
        abort = (comp > TO - 1);
        n     = abort ? TO : comp + 1;

        // IDLE: request presented, stall asserted combinationally
        next_cycle();
        mem_req = 1'b1; we_re = a_we; addr = a_addr; wdata = a_wdata; mask = a_mask;
        gnt = 1'b0; rvalid = 1'b0; rdata = $urandom;
        #1;
        total++;
        if ({stall_o, load_valid_o, err_o} !== 3'b100) begin
            bad++;
            $display("FAIL %s idle ctl got=%b exp=100", tag, {stall_o, load_valid_o, err_o});
        end
        total++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_mask_o} !== 70'd0) begin
            bad++;
            $display("FAIL %s idle bus got=%h exp=0", tag,
                     {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_mask_o});
        end

        // REQ/RESP: inputs scrambled, bus must show only the latched request
        for (int k = 0; k < n; k++) begin
            next_cycle();
            mem_req = 1'b1; we_re = 1'($urandom); addr = $urandom; wdata = $urandom;
            mask = 4'($urandom);
            gnt    = (k == g);
            rvalid = !a_we && (k == g + r);
            rdata  = rvalid ? a_rdata : $urandom;
            in_req  = (k <= g);
            bus_exp = in_req ? {1'b1, a_we, a_addr[31:2], 2'b00, a_wdata, a_mask} : 70'd0;
            #1;
            total++;
            if ({stall_o, load_valid_o, err_o} !== 3'b100) begin
                bad++;
                $display("FAIL %s wait k=%0d ctl got=%b exp=100", tag, k,
                         {stall_o, load_valid_o, err_o});
            end
            total++;
            if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_mask_o} !== bus_exp) begin
                bad++;
                $display("FAIL %s wait k=%0d bus got=%h exp=%h", tag, k,
                         {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_mask_o}, bus_exp);
            end
            total++;
            if (load_data_o !== ld_model) begin
                bad++;
                $display("FAIL %s wait k=%0d load_data got=%h exp=%h", tag, k, load_data_o, ld_model);
            end
        end

        // DONE: stall released, pulses, late bus activity ignored
        next_cycle();
        mem_req = hold;
        if (!hold) begin
            we_re = 1'($urandom); addr = $urandom; wdata = $urandom; mask = 4'($urandom);
        end
        gnt = 1'($urandom); rvalid = 1'($urandom); rdata = $urandom;
        if (!a_we) ld_model = abort ? 32'd0 : a_rdata;
        ctl_exp = {1'b0, !a_we && !abort, abort};
        #1;
        total++;
        if ({stall_o, load_valid_o, err_o} !== ctl_exp) begin
            bad++;
            $display("FAIL %s done ctl got=%b exp=%b", tag, {stall_o, load_valid_o, err_o}, ctl_exp);
        end
        total++;
        if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_mask_o} !== 70'd0) begin
            bad++;
            $display("FAIL %s done bus got=%h exp=0", tag,
                     {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_mask_o});
        end
        total++;
        if (load_data_o !== ld_model) begin
            bad++;
            $display("FAIL %s done load_data got=%h exp=%h", tag, load_data_o, ld_model);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({stall_o, load_valid_o, err_o, load_data_o, bus_req_o, bus_we_o,
             bus_addr_o, bus_wdata_o, bus_mask_o} !== 105'd0) begin
            bad++;
            $display("FAIL reset outputs not zero stall=%b lv=%b err=%b ld=%h req=%b",
                     stall_o, load_valid_o, err_o, load_data_o, bus_req_o);
        end
        next_cycle();
        rst_n = 1'b1;
        idle_cycles(2, "reset_idle");
    endtask

    task automatic test_store();
        run_access(1'b1, 32'h0000_1003, 32'hAB00_0000, 4'b1000, 0, 0, 32'd0, 1'b0, "store");
        idle_cycles(1, "store");
    endtask

    task automatic test_load_slow();
        run_access(1'b0, 32'h0000_2000, 32'd0, 4'b1111, 2, 3, 32'hDEAD_BEEF, 1'b0, "load_slow");
        idle_cycles(1, "load_slow");
    endtask

    task automatic test_load_fast();
        run_access(1'b0, 32'h0000_2004, 32'd0, 4'b1111, 0, 0, 32'h1234_5678, 1'b0, "load_fast");
        idle_cycles(1, "load_fast");
    endtask

    task automatic test_timeout();
        run_access(1'b0, 32'h0000_2008, 32'd0, 4'b1111, 1000, 0, 32'hFFFF_FFFF, 1'b0, "timeout");
        idle_cycles(3, "timeout_late");
    endtask

    task automatic test_back_to_back();
        int starts0;
        starts0 = req_starts;
        run_access(1'b0, 32'h0000_3000, 32'd0, 4'b1111, 0, 1, 32'hCAFE_F00D, 1'b1, "b2b_first");
        run_access(1'b0, 32'h0000_3004, 32'd0, 4'b0011, 1, 0, 32'h0BAD_F00D, 1'b0, "b2b_second");
        idle_cycles(2, "b2b");
        total++;
        if (req_starts - starts0 !== 2) begin
            bad++;
            $display("FAIL b2b request count got=%0d exp=2", req_starts - starts0);
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        mem_req = 1'b1; we_re = 1'b0; addr = 32'h0000_4000; wdata = $urandom; mask = 4'hF;
        gnt = 1'b0; rvalid = 1'b0;
        next_cycle();
        gnt = 1'b1; rvalid = 1'b0;
        next_cycle();
        gnt = 1'b0; rvalid = 1'b0;
        #1;
        total++;
        if ({stall_o, bus_req_o} !== 2'b10) begin
            bad++;
            $display("FAIL reset_mid resp state got=%b exp=10", {stall_o, bus_req_o});
        end
        mem_req = 1'b0;
        rst_n = 1'b0;
        #1;
        ld_model = 32'd0;
        total++;
        if ({stall_o, load_valid_o, err_o, load_data_o, bus_req_o, bus_we_o,
             bus_addr_o, bus_wdata_o, bus_mask_o} !== 105'd0) begin
            bad++;
            $display("FAIL reset_mid outputs not zero stall=%b lv=%b err=%b ld=%h req=%b",
                     stall_o, load_valid_o, err_o, load_data_o, bus_req_o);
        end
        next_cycle();
        rvalid = 1'b1; rdata = 32'h5555_AAAA;
        next_cycle();
        rst_n = 1'b1; rvalid = 1'b0;
        idle_cycles(2, "reset_mid_idle");
        run_access(1'b1, 32'h0000_5002, 32'h0000_7700, 4'b0100, 1, 0, 32'd0, 1'b0, "reset_mid_store");
        idle_cycles(1, "reset_mid_store");
    endtask

    task automatic test_random();
        logic hold;
        for (int i = 0; i < 30; i++) begin
            hold = 1'($urandom);
            run_access(1'($urandom), $urandom, $urandom, 4'($urandom),
                       int'($urandom_range(0, 9)), int'($urandom_range(0, 5)),
                       $urandom, hold, "random");
            if (!hold) idle_cycles(int'($urandom_range(0, 2)), "random");
        end
        idle_cycles(2, "random_end");
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_slow();
        test_load_fast();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
